// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder, plus the
// word-addressed store that stands in for simulated physical memory.
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } sram_state_t;

    localparam logic [ADDR_W-1:0] PMEM_BASE  = 32'h8000_0000;
    localparam int                PMEM_WORDS = 1024;
    localparam logic [ADDR_W-1:0] PMEM_BYTES = 32'(PMEM_WORDS * 4);

    // Backing store behind n_pmem_read/n_pmem_write; the window is 4 KiB at
    // PMEM_BASE, reads outside it return zero and writes outside it are dropped.
    logic [DATA_W-1:0] pmem [PMEM_WORDS];
    int unsigned       pmem_wr_calls;

    function automatic logic [DATA_W-1:0] n_pmem_read(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - PMEM_BASE;
        return (off < PMEM_BYTES) ? pmem[off[11:2]] : '0;
    endfunction

    // Upper mask bits belong to a 64-bit bus; a non-zero upper half never hits this 32-bit store.
    function automatic void n_pmem_write(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data,
                                         input logic [7:0]        mask);
        logic [ADDR_W-1:0] off;
        logic [DATA_W-1:0] word;
        off = addr - PMEM_BASE;
        pmem_wr_calls++;
        if (off < PMEM_BYTES && mask[7:4] == 4'h0) begin
            word = pmem[off[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
            end
            pmem[off[11:2]] = word;
        end
    endfunction

endpackage

// File: rtl/sram_lat_cnt.sv
// Loadable 4-bit latency down-counter; holds at zero instead of wrapping.
module sram_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/axi_lite_sram.sv
// Single-outstanding AXI4-Lite memory responder: one read or write at a time,
// completed against physical memory after RD_LAT / WR_LAT cycles.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    // Handshakes: a beat transfers on a rising edge where valid && ready.
    // AW and W are taken together or not at all, and a pending read wins, so
    // awready/wready only rise when the write is actually taken that edge.
    sram_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] word_addr;
    logic              idle;
    logic              rd_accept;
    logic              wr_accept;
    logic              cnt_zero;
    logic [3:0]        cnt_init;

    assign idle      = (state == IDLE) && rst;
    assign rd_accept = idle && arvalid;
    assign wr_accept = idle && !arvalid && awvalid && wvalid;
    assign arready   = idle;
    assign awready   = wr_accept;
    assign wready    = wr_accept;
    assign rresp     = RESP_OKAY;
    assign bresp     = RESP_OKAY;
    assign cnt_init  = rd_accept ? 4'(RD_LAT - 1) : 4'(WR_LAT - 1);
    assign word_addr = addr_q & ~32'h3;

    sram_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_accept || wr_accept),
        .load_val (cnt_init),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        addr_q <= araddr;
                        state  <= RD_WAIT;
                    end else if (wr_accept) begin
                        addr_q  <= awaddr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        state   <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_zero) begin
                        rdata  <= n_pmem_read(word_addr);
                        rvalid <= 1'b1;
                        state  <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    // The only point a write reaches memory; an empty strobe still gets a response.
                    if (cnt_zero) begin
                        if (wstrb_q != 4'h0) n_pmem_write(word_addr, wdata_q, {4'b0, wstrb_q});
                        bvalid <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: a fast (RD1/WR1) and a slow (RD3/WR4) instance
// share one stimulus set; sel routes the valids and picks which outputs are seen.
module tb_axi_lite_sram;
    import axi_lite_pkg::*;

    localparam int FAST_RD = 1;
    localparam int FAST_WR = 1;
    localparam int SLOW_RD = 3;
    localparam int SLOW_WR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;

    logic        arready_f, rvalid_f, awready_f, wready_f, bvalid_f;
    logic        arready_s, rvalid_s, awready_s, wready_s, bvalid_s;
    logic [31:0] rdata_f, rdata_s;
    logic [1:0]  rresp_f, rresp_s, bresp_f, bresp_s;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int          total = 0;
    int          bad = 0;
    int unsigned exp_calls = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [logic [31:0]];

    always #5 clk = ~clk;

    axi_lite_sram #(.RD_LAT(FAST_RD), .WR_LAT(FAST_WR)) dut_f (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid && !sel), .arready(arready_f),
        .rdata(rdata_f), .rresp(rresp_f), .rvalid(rvalid_f), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid && !sel), .awready(awready_f),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid && !sel), .wready(wready_f),
        .bresp(bresp_f), .bvalid(bvalid_f), .bready(bready)
    );

    axi_lite_sram #(.RD_LAT(SLOW_RD), .WR_LAT(SLOW_WR)) dut_s (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid && sel), .arready(arready_s),
        .rdata(rdata_s), .rresp(rresp_s), .rvalid(rvalid_s), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid && sel), .awready(awready_s),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid && sel), .wready(wready_s),
        .bresp(bresp_s), .bvalid(bvalid_s), .bready(bready)
    );

    assign arready = sel ? arready_s : arready_f;
    assign rvalid  = sel ? rvalid_s  : rvalid_f;
    assign awready = sel ? awready_s : awready_f;
    assign wready  = sel ? wready_s  : wready_f;
    assign bvalid  = sel ? bvalid_s  : bvalid_f;
    assign rdata   = sel ? rdata_s   : rdata_f;
    assign rresp   = sel ? rresp_s   : rresp_f;
    assign bresp   = sel ? bresp_s   : bresp_f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] key;
        key = addr & ~32'h3;
        return model_mem.exists(key) ? model_mem[key] : 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] w;
        w = model_word(addr);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        end
        model_mem[addr & ~32'h3] = w;
    endfunction

    function automatic int rd_lat_now();
        return sel ? SLOW_RD : FAST_RD;
    endfunction

    function automatic int wr_lat_now();
        return sel ? SLOW_WR : FAST_WR;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read with rready held low for 'hold' cycles after rvalid rises.
    task automatic do_read(input logic [31:0] addr, input int hold);
        int          n;
        logic [31:0] first;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        exp_q.push_back(model_word(addr));
        #1;
        n = 0;
        while (!arready && n < 64) begin step(); n++; end
        chk("rd_arready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 64) begin step(); n++; end
        chk("rd_lat", n, rd_lat_now());
        first = rdata;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_rdata", rdata, first);
            chk("bp_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        #1;
        chk("rd_busy_arready", 32'(arready), 32'd0);
        chk("rresp", 32'(rresp), 32'(RESP_OKAY));
        chk("rd_sb_size", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) chk("rd_data", rdata, exp_q.pop_front());
        step();
        rready = 1'b0;
        chk("rd_done_rvalid", 32'(rvalid), 32'd0);
        chk("rd_done_arready", 32'(arready), 32'd1);
    endtask

    // Write whose AW beat leads W by 'lead' cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int n;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b0;
        bready  = 1'b1;
        for (int i = 0; i < lead; i++) begin
            #1;
            chk("aw_alone_awready", 32'(awready), 32'd0);
            chk("aw_alone_wready", 32'(wready), 32'd0);
            step();
            chk("aw_alone_bvalid", 32'(bvalid), 32'd0);
        end
        wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 64) begin step(); n++; end
        chk("wr_awready", 32'(awready), 32'd1);
        chk("wr_wready", 32'(wready), 32'd1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 64) begin step(); n++; end
        chk("wr_lat", n, wr_lat_now());
        chk("bresp", 32'(bresp), 32'(RESP_OKAY));
        if (strb != 4'h0) begin
            model_write(addr, data, strb);
            exp_calls++;
        end
        chk("wr_calls", pmem_wr_calls, exp_calls);
        step();
        chk("wr_done_bvalid", 32'(bvalid), 32'd0);
        bready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int          n;
        logic [31:0] a, d;
        rst = 1'b0; sel = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_arready", 32'(arready), 32'd1);

        do_write(32'h8000_0000, 32'h0000_0413, 4'hF, 0);
        do_write(32'h8000_0104, 32'h1122_3344, 4'hF, 0);

        // Fresh reset, then the first read lands in the very first cycle.
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst2_arready", 32'(arready), 32'd1);
        do_read(32'h8000_0000, 0);

        do_write(32'h8000_0104, 32'h0000_00AB, 4'b0001, 0);
        do_read(32'h8000_0104, 0);

        sel = 1'b1;
        do_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0);
        do_read(32'h8000_0010, 5);

        // Read and write offered together: the read is serviced first.
        sel = 1'b0;
        araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        exp_q.push_back(model_word(32'h8000_0000));
        #1;
        chk("both_arready", 32'(arready), 32'd1);
        chk("both_awready", 32'(awready), 32'd0);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 64) begin step(); n++; end
        chk("both_rd_lat", n, FAST_RD);
        chk("both_awready_busy", 32'(awready), 32'd0);
        chk("both_rd_sb_size", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) chk("both_rd_data", rdata, exp_q.pop_front());
        step();
        chk("both_wr_pending_calls", pmem_wr_calls, exp_calls);
        chk("both_wr_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        n = 0;
        while (!bvalid && n < 64) begin step(); n++; end
        chk("both_wr_lat", n, FAST_WR);
        model_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF);
        exp_calls++;
        step();
        bready = 1'b0;
        do_read(32'h8000_0020, 0);

        // Reset while the slow instance is still counting down a write.
        sel = 1'b1;
        do_write(32'h8000_0200, 32'h55AA_55AA, 4'hF, 0);
        awaddr = 32'h8000_0200; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 64) begin step(); n++; end
        chk("rstw_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("rstw_bvalid", 32'(bvalid), 32'd0);
        chk("rstw_arready", 32'(arready), 32'd0);
        chk("rstw_calls", pmem_wr_calls, exp_calls);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstw_rel_arready", 32'(arready), 32'd1);
        repeat (6) step();
        chk("rstw_late_calls", pmem_wr_calls, exp_calls);
        chk("rstw_late_bvalid", 32'(bvalid), 32'd0);
        bready = 1'b0;
        do_read(32'h8000_0200, 0);

        sel = 1'b0;
        do_write(32'h8000_0030, 32'h1234_5678, 4'hF, 3);
        do_write(32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 0);
        do_read(32'h8000_0030, 0);

        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom_range(0, 1));
            a = 32'h8000_0400 + 32'(4 * $urandom_range(0, 15));
            d = $urandom;
            do_write(a, d, 4'hF, 0);
            d = $urandom;
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            do_read(a, $urandom_range(0, 3));
        end

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
